// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register file and its writeback
// scheduler.
//   DATA_W   : register data width
//   ADDR_W   : register index width
//   NUM_REGS : number of architectural registers
//   REQ_ALU  : writeback requester id for the ALU path; also its grant bit
//   REQ_MEM  : writeback requester id for the load path; also its grant bit
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin arbiter that remembers the last winner.
//   clk, rst : clock; asynchronous active-high reset
//   req      : request vector, indexed by REQ_ALU / REQ_MEM
//   grant    : one-hot grant; a bit is set only when its request is set
// A grant is also the acceptance, so `last` moves whenever any bit of
// grant is set.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last;  // id of the most recent winner

  always_comb begin
    grant = req;
    // On contention the requester that did not win last time goes first.
    if (req[REQ_ALU] && req[REQ_MEM]) begin
      grant = '0;
      if (last == 1'(REQ_MEM)) grant[REQ_ALU] = 1'b1;
      else                     grant[REQ_MEM] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= 1'(REQ_MEM);
    else if (|grant) last <= grant[REQ_MEM];
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: busy scoreboard for issue hazards plus arbitration
// of the single register-file write port between ALU and load writebacks.
//   clk, rst                      : clock; asynchronous active-high reset
//   iss_valid/rd/rs1/rs2          : instruction offered by decode
//   iss_wr/use1/use2              : instruction writes rd / reads rs1 / rs2
//   iss_ready                     : no RAW/WAW hazard and no flush
//   flush                         : clears the scoreboard at the next edge
//   alu_valid/rd/data, alu_ready  : ALU writeback handshake
//   mem_valid/rd/data, mem_ready  : load writeback handshake
//   rf_w_en/rf_rd/rf_wdata        : registered register-file write port
//   busy                          : scoreboard, bit 0 always 0
//   wb_err                        : sticky, writeback to a non-busy register
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic [ADDR_W-1:0]   iss_rs1,
  input  logic [ADDR_W-1:0]   iss_rs2,
  input  logic                iss_wr,
  input  logic                iss_use1,
  input  logic                iss_use2,
  output logic                iss_ready,
  input  logic                flush,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  output logic                rf_w_en,
  output logic [ADDR_W-1:0]   rf_rd,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] busy,
  output logic                wb_err
);

  logic [1:0]          grant;
  logic                wb_acc;
  logic [ADDR_W-1:0]   wb_rd;
  logic [DATA_W-1:0]   wb_data;
  logic                haz1, haz2, hazd;
  logic                iss_acc;
  logic [NUM_REGS-1:0] busy_nxt;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({mem_valid, alu_valid}),
    .grant (grant)
  );

  assign alu_ready = grant[REQ_ALU];
  assign mem_ready = grant[REQ_MEM];
  assign wb_acc    = |grant;
  assign wb_rd     = grant[REQ_MEM] ? mem_rd   : alu_rd;
  assign wb_data   = grant[REQ_MEM] ? mem_data : alu_data;

  // r0 is never tracked, so reads/writes of it never stall.
  assign haz1      = iss_use1 && (iss_rs1 != '0) && busy[iss_rs1];
  assign haz2      = iss_use2 && (iss_rs2 != '0) && busy[iss_rs2];
  assign hazd      = iss_wr   && (iss_rd  != '0) && busy[iss_rd];
  assign iss_ready = !(haz1 || haz2 || hazd || flush);
  assign iss_acc   = iss_valid && iss_ready;

  always_comb begin
    busy_nxt = busy;
    // Clear is applied first so a coincident set on the same bit wins.
    if (rf_w_en)                         busy_nxt[rf_rd]  = 1'b0;
    if (iss_acc && iss_wr)               busy_nxt[iss_rd] = 1'b1;
    if (flush)                           busy_nxt         = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      rf_w_en  <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      rf_w_en <= wb_acc;
      if (wb_acc) begin
        rf_rd    <= wb_rd;
        rf_wdata <= wb_data;
        if ((wb_rd != '0) && !busy[wb_rd]) wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                iss_valid, iss_wr, iss_use1, iss_use2, iss_ready, flush;
  logic [ADDR_W-1:0]   iss_rd, iss_rs1, iss_rs2;
  logic                alu_valid, alu_ready, mem_valid, mem_ready;
  logic [ADDR_W-1:0]   alu_rd, mem_rd, rf_rd;
  logic [DATA_W-1:0]   alu_data, mem_data, rf_wdata;
  logic                rf_w_en, wb_err;
  logic [NUM_REGS-1:0] busy;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] rf_model [NUM_REGS];

  always #5 clk = ~clk;

  // Behavioural register file fed by the scheduler's write port.
  always @(posedge clk)
    if (rf_w_en && rf_rd != '0) rf_model[rf_rd] <= rf_wdata;

  regfile_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_wr(iss_wr), .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_ready(iss_ready),
    .flush(flush),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_w_en(rf_w_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy), .wb_err(wb_err)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_wr = 0; iss_use1 = 0; iss_use2 = 0;
    iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0; flush = 0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic issue_wr(input logic [ADDR_W-1:0] rd);
    idle();
    iss_valid = 1; iss_wr = 1; iss_rd = rd; #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      failures++; $display("FAIL issue_wr_ready rd=%0d got=%b exp=1", rd, iss_ready);
    end
    tick(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1; #1;
    checks++;
    if ({rf_w_en, rf_rd, rf_wdata, busy, wb_err} !== '0) begin
      failures++; $display("FAIL reset_state got w_en=%b rd=%0d wd=%h busy=%h err=%b exp all 0",
                           rf_w_en, rf_rd, rf_wdata, busy, wb_err);
    end
    alu_valid = 1; #1;
    checks++;
    if ({alu_ready, mem_ready} !== 2'b10) begin
      failures++; $display("FAIL reset_ready got alu=%b mem=%b exp alu=1 mem=0", alu_ready, mem_ready);
    end
    idle();
    tick(); rst = 0; tick();
  endtask

  task automatic test_single_wb();
    issue_wr(5);
    checks++;
    if (busy !== 32'h20) begin failures++; $display("FAIL single_busy_set got=%h exp=00000020", busy); end
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234; #1;
    checks++;
    if (alu_ready !== 1'b1) begin failures++; $display("FAIL single_alu_ready got=%b exp=1", alu_ready); end
    tick(); idle();
    checks++;
    if (rf_w_en !== 1 || rf_rd !== 5 || rf_wdata !== 32'h1234 || busy !== 32'h20) begin
      failures++; $display("FAIL single_wb_out got w_en=%b rd=%0d wd=%h busy=%h exp 1/5/1234/00000020",
                           rf_w_en, rf_rd, rf_wdata, busy);
    end
    tick();
    checks++;
    if (rf_w_en !== 0 || busy !== '0 || wb_err !== 0) begin
      failures++; $display("FAIL single_wb_after got w_en=%b busy=%h err=%b exp 0/0/0", rf_w_en, busy, wb_err);
    end
  endtask

  task automatic test_raw();
    issue_wr(7);
    iss_valid = 1; iss_use1 = 1; iss_rs1 = 7; #1;
    checks++;
    if (iss_ready !== 0) begin failures++; $display("FAIL raw_stall got=%b exp=0", iss_ready); end
    iss_use1 = 0; iss_wr = 1; iss_rd = 7; #1;
    checks++;
    if (iss_ready !== 0) begin failures++; $display("FAIL waw_stall got=%b exp=0", iss_ready); end
    iss_wr = 0; iss_use1 = 1;
    alu_valid = 1; alu_rd = 7; alu_data = 32'hCAFE;   // accept cycle N
    tick();
    alu_valid = 0; #1;
    checks++;
    if (iss_ready !== 0) begin failures++; $display("FAIL raw_n1 got=%b exp=0", iss_ready); end
    tick();                                            // cycle N+2
    checks++;
    if (iss_ready !== 1 || rf_model[7] !== 32'hCAFE) begin
      failures++; $display("FAIL raw_n2 got ready=%b rf7=%h exp 1/cafe", iss_ready, rf_model[7]);
    end
    tick(); idle();
  endtask

  task automatic test_wb_err_rd0();
    logic [NUM_REGS-1:0] b;
    mem_valid = 1; mem_rd = 9; mem_data = 32'h99; tick();
    mem_valid = 0;
    checks++;
    if (rf_w_en !== 1 || rf_rd !== 9 || rf_wdata !== 32'h99 || wb_err !== 1) begin
      failures++; $display("FAIL wb_err_fwd got w_en=%b rd=%0d wd=%h err=%b exp 1/9/99/1",
                           rf_w_en, rf_rd, rf_wdata, wb_err);
    end
    b = busy;
    mem_valid = 1; mem_rd = 0; mem_data = 32'h55; tick();
    mem_valid = 0;
    checks++;
    if (rf_w_en !== 1 || rf_rd !== 0 || rf_wdata !== 32'h55 || wb_err !== 1) begin
      failures++; $display("FAIL rd0_fwd got w_en=%b rd=%0d wd=%h err=%b exp 1/0/55/1",
                           rf_w_en, rf_rd, rf_wdata, wb_err);
    end
    tick();
    checks++;
    if (busy !== b || busy[0] !== 0) begin failures++; $display("FAIL rd0_busy got=%h exp=%h", busy, b); end
    idle();
  endtask

  task automatic test_back_to_back();
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA3;
    mem_valid = 1; mem_rd = 4; mem_data = 32'hB4;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin
        failures++; $display("FAIL rr_grant%0d got alu=%b mem=%b exp alu=%b", i, alu_ready, mem_ready, (i % 2 == 0));
      end
      tick();
      if (i == 3) begin alu_valid = 0; mem_valid = 0; end
      checks++;
      if (rf_w_en !== 1 || rf_rd !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin
        failures++; $display("FAIL rr_wb%0d got w_en=%b rd=%0d exp 1/%0d", i, rf_w_en, rf_rd, (i % 2 == 0) ? 3 : 4);
      end
    end
    tick();
    checks++;
    if (rf_w_en !== 0) begin failures++; $display("FAIL rr_idle got=%b exp=0", rf_w_en); end
    idle();
  endtask

  task automatic test_flush();
    issue_wr(1); issue_wr(2); issue_wr(3);
    checks++;
    if (busy !== 32'hE) begin failures++; $display("FAIL flush_pre got=%h exp=0000000e", busy); end
    iss_valid = 1; iss_wr = 1; iss_rd = 10; flush = 1;
    mem_valid = 1; mem_rd = 2; mem_data = 32'h77; #1;
    checks++;
    if (iss_ready !== 0 || mem_ready !== 1) begin
      failures++; $display("FAIL flush_block got ready=%b mem_ready=%b exp 0/1", iss_ready, mem_ready);
    end
    tick(); idle();
    checks++;
    if (busy !== '0 || rf_w_en !== 1 || rf_rd !== 2 || rf_wdata !== 32'h77) begin
      failures++; $display("FAIL flush_after got busy=%h w_en=%b rd=%0d wd=%h exp 0/1/2/77",
                           busy, rf_w_en, rf_rd, rf_wdata);
    end
    tick();
  endtask

  task automatic test_async_reset();
    issue_wr(6);
    alu_valid = 1; alu_rd = 6; alu_data = 32'hAB; tick(); idle();
    checks++;
    if (rf_w_en !== 1 || busy !== 32'h40) begin
      failures++; $display("FAIL areset_pre got w_en=%b busy=%h exp 1/00000040", rf_w_en, busy);
    end
    #2 rst = 1; #1;
    checks++;
    if ({rf_w_en, rf_rd, rf_wdata, busy, wb_err} !== '0) begin
      failures++; $display("FAIL areset_now got w_en=%b rd=%0d wd=%h busy=%h err=%b exp all 0",
                           rf_w_en, rf_rd, rf_wdata, busy, wb_err);
    end
    tick(); rst = 0; tick();
    alu_valid = 1; mem_valid = 1; #1;
    checks++;
    if (alu_ready !== 1 || mem_ready !== 0) begin
      failures++; $display("FAIL areset_last got alu=%b mem=%b exp 1/0", alu_ready, mem_ready);
    end
    tick(); idle();
  endtask

  initial begin
    rst = 1; idle();
    test_reset();
    test_single_wb();
    test_raw();
    test_wb_err_rd0();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
